// File: rtl/fetch_queue_if.sv
// Fetch front-end bundle: instruction-memory request/response, execute redirect and decode handoff.
// master = fetch_queue side, slave = memory/pipeline side.
interface fetch_queue_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        dec_stall;
   logic        dec_valid;
   logic [31:0] dec_instr;
   logic [31:0] dec_pc;
   logic [31:0] dec_pc_plus4;

   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rsp_data,
      input  redirect_valid,
      input  redirect_pc,
      input  dec_stall,
      output dec_valid,
      output dec_instr,
      output dec_pc,
      output dec_pc_plus4
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rsp_data,
      output redirect_valid,
      output redirect_pc,
      output dec_stall,
      input  dec_valid,
      input  dec_instr,
      input  dec_pc,
      input  dec_pc_plus4
   );
endinterface

// File: rtl/fetch_queue.sv
// Sequential-PC instruction fetch with credit-limited requests, in-order response FIFO and
// redirect flush. Define FETCH_QUEUE_BYPASS_EN for same-cycle response-to-decode bypass.
module fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic           clk,
   input logic           reset,
   fetch_queue_if.master fq
);

   localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned      CNT_W    = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [31:0]      NOP      = 32'h0000_0013;

   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] tag_rd_q, tag_rd_d;
   logic [PTR_W-1:0] tag_wr_q, tag_wr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] inflight_q, inflight_d;
   logic [CNT_W-1:0] drop_q, drop_d;

   logic [31:0] instr_mem_q [DEPTH];
   logic [31:0] pc_mem_q    [DEPTH];
   logic [31:0] tag_mem_q   [DEPTH];

   logic [CNT_W:0] credit_used;
   logic           req_valid;
   logic           req_fire;
   logic           rsp_keep;
   logic [31:0]    rsp_tag;
   logic           fifo_empty;
   logic           bypass_hit;
   logic           dec_valid;
   logic           pop;
   logic           pop_fifo;
   logic           push;
   logic           unused_redirect_lsb;

   assign unused_redirect_lsb = ^fq.redirect_pc[1:0];

   // Slots already queued plus slots promised to in-flight responses bound new requests.
   assign credit_used = {1'b0, count_q} + {1'b0, inflight_q};
   assign req_valid   = !reset && !fq.redirect_valid && (credit_used < {1'b0, CNT_FULL});
   assign req_fire    = req_valid && fq.imem_req_ready;

   assign rsp_tag    = tag_mem_q[tag_rd_q];
   assign rsp_keep   = fq.imem_rsp_valid && (drop_q == '0) && !fq.redirect_valid;
   assign fifo_empty = (count_q == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
   assign bypass_hit = rsp_keep && fifo_empty;
`else
   assign bypass_hit = 1'b0;
`endif

   assign dec_valid = !fifo_empty || bypass_hit;
   assign pop       = dec_valid && !fq.dec_stall && !fq.redirect_valid;
   assign pop_fifo  = pop && !fifo_empty;
   // A bypassed response consumed by decode this cycle never touches storage.
   assign push      = rsp_keep && !(bypass_hit && pop);

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      tag_rd_d   = tag_rd_q;
      tag_wr_d   = tag_wr_q;
      count_d    = count_q;
      inflight_d = inflight_q;
      drop_d     = drop_q;

      if (req_fire) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
         tag_wr_d   = tag_wr_q + PTR_ONE;
         inflight_d = inflight_d + CNT_ONE;
      end

      if (fq.imem_rsp_valid) begin
         tag_rd_d   = tag_rd_q + PTR_ONE;
         inflight_d = inflight_d - CNT_ONE;
         if (drop_q != '0) begin
            drop_d = drop_q - CNT_ONE;
         end
      end

      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
         count_d  = count_d + CNT_ONE;
      end

      if (pop_fifo) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
         count_d  = count_d - CNT_ONE;
      end

      // Every request still outstanding after this edge belongs to the old stream.
      if (fq.redirect_valid) begin
         fetch_pc_d = {fq.redirect_pc[31:2], 2'b00};
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         drop_d     = inflight_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         tag_rd_q   <= '0;
         tag_wr_q   <= '0;
         count_q    <= '0;
         inflight_q <= '0;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         tag_rd_q   <= tag_rd_d;
         tag_wr_q   <= tag_wr_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem_q[wr_ptr_q] <= fq.imem_rsp_data;
         pc_mem_q[wr_ptr_q]    <= rsp_tag;
      end
      if (req_fire) begin
         tag_mem_q[tag_wr_q] <= fetch_pc_q;
      end
   end

   always_comb begin
      fq.imem_req_valid = req_valid;
      fq.imem_req_addr  = fetch_pc_q;
      fq.dec_valid      = dec_valid;
      fq.dec_instr      = NOP;
      fq.dec_pc         = 32'h0000_0000;
      if (bypass_hit) begin
         fq.dec_instr = fq.imem_rsp_data;
         fq.dec_pc    = rsp_tag;
      end else if (!fifo_empty) begin
         fq.dec_instr = instr_mem_q[rd_ptr_q];
         fq.dec_pc    = pc_mem_q[rd_ptr_q];
      end
      fq.dec_pc_plus4 = fq.dec_pc + 32'd4;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(push && !pop_fifo && (count_q == CNT_FULL)));
         assert (!(fq.imem_rsp_valid && (inflight_q == '0)));
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: vector table for reset/stream/backpressure, plus hand
// sequences for ready stalls, redirect drop, same-cycle redirect, PC wrap and mid-stream reset.
module tb_fetch_queue;

`ifdef FETCH_QUEUE_BYPASS_EN
   localparam int BYP = 1;
`else
   localparam int BYP = 0;
`endif
   localparam logic [31:0] RST_PC = 32'h0000_0040;
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] KEY    = 32'hCAFE_0000;

   logic clk;
   logic reset;
   fetch_queue_if bus ();

   fetch_queue #(
      .DEPTH    (4),
      .RESET_PC (RST_PC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .fq    (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        rst;
      logic        stall;
      logic        chk_dec;
      logic        exp_req_v;
      logic [31:0] exp_addr;
      logic        exp_dec_v;
      logic [31:0] exp_pc;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      int          due;
   } mreq_t;

   vec_t  vq[$];
   mreq_t mq[$];
   int    cyc;
   int    lat;
   int    errors;
   int    checks;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic rst, input logic stall, input logic chk_dec,
                          input logic req_v, input logic [31:0] addr, input logic dec_v,
                          input logic [31:0] pc);
      vec_t v;
      v.rst = rst; v.stall = stall; v.chk_dec = chk_dec;
      v.exp_req_v = req_v; v.exp_addr = addr;
      v.exp_dec_v = dec_v; v.exp_pc = dec_v ? pc : 32'h0;
      vq.push_back(v);
   endtask

   // Called at the sample point; advances to 1 time unit after the next posedge and
   // presents the in-order memory response for the new cycle.
   task automatic tick();
      logic        fired;
      logic [31:0] faddr;
      logic        was_rst;
      mreq_t       m;
      fired   = bus.imem_req_valid && bus.imem_req_ready;
      faddr   = bus.imem_req_addr;
      was_rst = reset;
      @(posedge clk);
      #1;
      cyc++;
      if (was_rst) begin
         mq.delete();
      end else if (fired) begin
         m.data = faddr ^ KEY;
         m.due  = cyc + lat - 1;
         mq.push_back(m);
      end
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = mq[0].data;
         void'(mq.pop_front());
      end else begin
         bus.imem_rsp_valid = 1'b0;
         bus.imem_rsp_data  = 32'h0;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #4;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] wexp [3];
      int          idx;
      bit          found;
      vec_t        v;

      errors = 0; checks = 0; cyc = 0; lat = 1;
      reset = 1'b1;
      bus.imem_req_ready = 1'b1;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      bus.dec_stall      = 1'b0;

      // Reset state
      add_vec(1, 0, 1, 0, 0, 0, 0);
      add_vec(1, 0, 1, 0, 0, 0, 0);
      // Free-running stream, 1-cycle memory
      for (int k = 0; k < 8; k++)
         add_vec(0, 0, 1, 1, RST_PC + 32'(4 * k), (k >= 2 - BYP),
                 RST_PC + 32'(4 * (k - 2 + BYP)));
      // Mid-stream reset, then decode stalled for 10 cycles from reset
      add_vec(1, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 16; k++)
         add_vec(0, (k < 10), 1, (k < 4) || (k > 10),
                 (k < 4) ? RST_PC + 32'(4 * k) : RST_PC + 32'(4 * (k - 7)),
                 (k >= 2 - BYP), (k < 10) ? RST_PC : RST_PC + 32'(4 * (k - 10)));

      tick();
      for (int i = 0; i < vq.size(); i++) begin
         v = vq[i];
         reset = v.rst;
         bus.dec_stall = v.stall;
         #4;
         chk($sformatf("v%0d req_valid", i), bus.imem_req_valid, v.exp_req_v);
         if (v.exp_req_v)
            chk($sformatf("v%0d req_addr", i), bus.imem_req_addr, v.exp_addr);
         if (v.chk_dec) begin
            chk($sformatf("v%0d dec_valid", i), bus.dec_valid, v.exp_dec_v);
            chk($sformatf("v%0d dec_pc", i), bus.dec_pc, v.exp_pc);
            chk($sformatf("v%0d dec_pc_plus4", i), bus.dec_pc_plus4, v.exp_pc + 32'd4);
            chk($sformatf("v%0d dec_instr", i), bus.dec_instr,
                v.exp_dec_v ? (v.exp_pc ^ KEY) : NOP);
         end
         tick();
      end

      // Memory not ready: address holds, then advances once accepted
      bus.dec_stall = 1'b0;
      do_reset();
      bus.imem_req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #4;
         chk("notready req_valid", bus.imem_req_valid, 1'b1);
         chk("notready req_addr", bus.imem_req_addr, RST_PC);
         tick();
      end
      bus.imem_req_ready = 1'b1;
      #4;
      chk("ready req_addr", bus.imem_req_addr, RST_PC);
      tick();
      #4;
      chk("ready next_addr", bus.imem_req_addr, RST_PC + 32'd4);
      tick();

      // Redirect with three requests in flight (4-cycle memory)
      lat = 4;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         #4;
         tick();
      end
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_0103;
      #4;
      chk("redir3 req_blocked", bus.imem_req_valid, 1'b0);
      tick();
      bus.redirect_valid = 1'b0;
      #4;
      chk("redir3 req_valid", bus.imem_req_valid, 1'b1);
      chk("redir3 req_addr", bus.imem_req_addr, 32'h0000_0100);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (bus.dec_valid) begin
            found = 1'b1;
            chk("redir3 first_pc", bus.dec_pc, 32'h0000_0100);
            chk("redir3 first_instr", bus.dec_instr, 32'h0000_0100 ^ KEY);
         end
         tick();
         #4;
      end
      if (!found) chk("redir3 dec_timeout", 32'(found), 32'd1);
      tick();

      // Redirect in the same cycle as a response and a pop
      lat = 1;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         #4;
         tick();
      end
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_0200;
      #4;
      chk("redir1 rsp_present", bus.imem_rsp_valid, 1'b1);
      tick();
      bus.redirect_valid = 1'b0;
      #4;
      chk("redir1 dec_flushed", bus.dec_valid, 1'b0);
      chk("redir1 instr_nop", bus.dec_instr, NOP);
      chk("redir1 req_addr", bus.imem_req_addr, 32'h0000_0200);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (bus.dec_valid) begin
            found = 1'b1;
            chk("redir1 first_pc", bus.dec_pc, 32'h0000_0200);
         end
         tick();
         #4;
      end
      if (!found) chk("redir1 dec_timeout", 32'(found), 32'd1);
      tick();

      // Address wrap at the top of memory; low redirect bits ignored
      wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC; wexp[2] = 32'h0000_0000;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'hFFFF_FFFA;
      #4;
      tick();
      bus.redirect_valid = 1'b0;
      idx = 0;
      for (int i = 0; i < 12; i++) begin
         #4;
         if (i < 3) chk($sformatf("wrap req_addr%0d", i), bus.imem_req_addr, wexp[i]);
         if (bus.dec_valid && idx < 3) begin
            chk($sformatf("wrap dec_pc%0d", idx), bus.dec_pc, wexp[idx]);
            chk($sformatf("wrap plus4_%0d", idx), bus.dec_pc_plus4, wexp[idx] + 32'd4);
            chk($sformatf("wrap instr%0d", idx), bus.dec_instr, wexp[idx] ^ KEY);
            idx++;
         end
         tick();
      end
      chk("wrap delivered", 32'(idx), 32'd3);

      // Reset with a full FIFO
      bus.dec_stall = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #4;
         tick();
      end
      #4;
      chk("full no_req", bus.imem_req_valid, 1'b0);
      chk("full dec_valid", bus.dec_valid, 1'b1);
      do_reset();
      #4;
      chk("rst_full dec_valid", bus.dec_valid, 1'b0);
      chk("rst_full dec_instr", bus.dec_instr, NOP);
      chk("rst_full dec_pc", bus.dec_pc, 32'h0);
      chk("rst_full dec_pc_plus4", bus.dec_pc_plus4, 32'h4);
      chk("rst_full req_valid", bus.imem_req_valid, 1'b1);
      chk("rst_full req_addr", bus.imem_req_addr, RST_PC);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
